us_ranger_ctrl: RTL and testbench

- Ultrasonic (HC-SR04 style) ranging controller directly downstream of the slow measurement-rate clock divider.
- Takes the divider's slow square wave as a request level. Each rising edge of that level starts one measurement: a trigger pulse is sent, the echo width is timed, and the result is converted to centimetres.
- Produces a registered distance, a one-cycle valid strobe and a timeout flag for the game logic.

---
 rtl/us_ranger_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_us_ranger_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/us_ranger_ctrl.sv
// HC-SR04 style ranging controller: one trigger per rising edge of the request level,
// echo width timed in microsecond ticks and converted to whole centimetres.
module us_ranger_ctrl #(
    parameter int unsigned CLK_MHZ      = 100,
    parameter int unsigned TRIG_US      = 10,
    parameter int unsigned US_PER_CM    = 58,
    parameter int unsigned ECHO_WAIT_US = 1000,
    parameter int unsigned TIMEOUT_US   = 30000,
    parameter int unsigned HOLDOFF_US   = 10000,
    parameter int unsigned MAX_CM       = 400
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       meas_req,
    input  logic       echo,
    output logic       trig,
    output logic [8:0] dist_cm,
    output logic       valid,
    output logic       timeout,
    output logic       busy
);

    localparam int unsigned PRESC_W = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
    localparam int unsigned MAX_A   = (TIMEOUT_US > HOLDOFF_US) ? TIMEOUT_US : HOLDOFF_US;
    localparam int unsigned MAX_B   = (MAX_A > ECHO_WAIT_US) ? MAX_A : ECHO_WAIT_US;
    localparam int unsigned US_MAX  = (MAX_B > TRIG_US) ? MAX_B : TRIG_US;
    localparam int unsigned US_W    = (US_MAX > 1) ? $clog2(US_MAX) : 1;
    localparam int unsigned SUB_W   = (US_PER_CM > 1) ? $clog2(US_PER_CM) : 1;

    localparam logic [PRESC_W-1:0] PRESC_LAST   = PRESC_W'(CLK_MHZ - 1);
    localparam logic [US_W-1:0]    TRIG_LAST    = US_W'(TRIG_US - 1);
    localparam logic [US_W-1:0]    ECHO_LAST    = US_W'(ECHO_WAIT_US - 1);
    localparam logic [US_W-1:0]    TIMEOUT_LAST = US_W'(TIMEOUT_US - 1);
    localparam logic [US_W-1:0]    HOLD_LAST    = US_W'(HOLDOFF_US - 1);
    localparam logic [SUB_W-1:0]   SUB_LAST     = SUB_W'(US_PER_CM - 1);
    localparam logic [8:0]         CM_SAT       = 9'(MAX_CM);

    typedef enum logic [2:0] {
        StIdle,
        StTrig,
        StWaitEcho,
        StMeasure,
        StDone,
        StTimeoutRes,
        StHoldoff
    } state_e;

    state_e             state;
    logic               req_meta, req_s, req_s_d;
    logic               echo_meta, echo_s;
    logic [PRESC_W-1:0] presc;
    logic [US_W-1:0]    us_cnt;
    logic [SUB_W-1:0]   sub_cm;
    logic [8:0]         cm;
    logic               tick;
    logic               req_rise;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            req_meta  <= 1'b0;
            req_s     <= 1'b0;
            req_s_d   <= 1'b0;
            echo_meta <= 1'b0;
            echo_s    <= 1'b0;
        end else begin
            req_meta  <= meas_req;
            req_s     <= req_meta;
            req_s_d   <= req_s;
            echo_meta <= echo;
            echo_s    <= echo_meta;
        end
    end

    assign req_rise = req_s & ~req_s_d;
    assign tick     = (presc == PRESC_LAST);

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state   <= StIdle;
            presc   <= '0;
            us_cnt  <= '0;
            sub_cm  <= '0;
            cm      <= '0;
            trig    <= 1'b0;
            dist_cm <= '0;
            valid   <= 1'b0;
            timeout <= 1'b0;
            busy    <= 1'b0;
        end else begin
            valid <= 1'b0;
            presc <= tick ? '0 : presc + 1'b1;
            unique case (state)
                StIdle: begin
                    if (req_rise) begin
                        state  <= StTrig;
                        trig   <= 1'b1;
                        busy   <= 1'b1;
                        presc  <= '0;
                        us_cnt <= '0;
                    end
                end
                StTrig: begin
                    if (tick) begin
                        if (us_cnt == TRIG_LAST) begin
                            state  <= StWaitEcho;
                            trig   <= 1'b0;
                            presc  <= '0;
                            us_cnt <= '0;
                        end else begin
                            us_cnt <= us_cnt + 1'b1;
                        end
                    end
                end
                StWaitEcho: begin
                    if (echo_s) begin
                        state  <= StMeasure;
                        presc  <= '0;
                        us_cnt <= '0;
                        sub_cm <= '0;
                        cm     <= '0;
                    end else if (tick) begin
                        if (us_cnt == ECHO_LAST) begin
                            state <= StTimeoutRes;
                        end else begin
                            us_cnt <= us_cnt + 1'b1;
                        end
                    end
                end
                StMeasure: begin
                    // Timeout wins over a simultaneous echo fall. The tick in the
                    // echo-low cycle still counts, balancing the cycle lost on entry.
                    if (tick && us_cnt == TIMEOUT_LAST) begin
                        state <= StTimeoutRes;
                    end else begin
                        if (tick) begin
                            us_cnt <= us_cnt + 1'b1;
                            if (sub_cm == SUB_LAST) begin
                                sub_cm <= '0;
                                if (cm != CM_SAT) begin
                                    cm <= cm + 1'b1;
                                end
                            end else begin
                                sub_cm <= sub_cm + 1'b1;
                            end
                        end
                        if (!echo_s) begin
                            state <= StDone;
                        end
                    end
                end
                StDone: begin
                    dist_cm <= cm;
                    timeout <= 1'b0;
                    valid   <= 1'b1;
                    us_cnt  <= '0;
                    state   <= StHoldoff;
                end
                StTimeoutRes: begin
                    dist_cm <= CM_SAT;
                    timeout <= 1'b1;
                    valid   <= 1'b1;
                    us_cnt  <= '0;
                    state   <= StHoldoff;
                end
                StHoldoff: begin
                    if (tick) begin
                        if (us_cnt == HOLD_LAST) begin
                            state <= StIdle;
                            busy  <= 1'b0;
                        end else begin
                            us_cnt <= us_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= StIdle;
                    trig  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_us_ranger_ctrl.sv
// Directed bench for us_ranger_ctrl with a 10-cycle microsecond tick.
module tb_us_ranger_ctrl;

    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    logic       meas_req = 1'b0;
    logic       echo = 1'b0;
    logic       trig;
    logic [8:0] dist_cm;
    logic       valid;
    logic       timeout;
    logic       busy;

    int unsigned n_tests = 0;
    int unsigned n_fail = 0;
    int unsigned valid_cnt = 0;

    us_ranger_ctrl #(
        .CLK_MHZ     (10),
        .TRIG_US     (10),
        .US_PER_CM   (58),
        .ECHO_WAIT_US(100),
        .TIMEOUT_US  (2000),
        .HOLDOFF_US  (50),
        .MAX_CM      (400)
    ) dut (
        .clk_in  (clk_in),
        .rst     (rst),
        .meas_req(meas_req),
        .echo    (echo),
        .trig    (trig),
        .dist_cm (dist_cm),
        .valid   (valid),
        .timeout (timeout),
        .busy    (busy)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (valid) valid_cnt++;
    end

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // rise=0: echo never rises; stuck=1: echo held high past the timeout and holdoff.
    // poke=1: extra request edges during MEASURE and HOLDOFF, which must be ignored.
    task automatic measure(input int unsigned high_us, input bit rise, input bit stuck,
                           input bit poke, input int unsigned exp_cm, input bit exp_to);
        int unsigned v0;
        int unsigned n;
        meas_req = 1'b0;
        repeat (4) @(negedge clk_in);
        v0 = valid_cnt;
        meas_req = 1'b1;
        n = 0;
        while (!trig && n < 100) begin
            @(negedge clk_in);
            n++;
        end
        check("trig_start", trig, 1);
        n = 0;
        while (trig && n < 1000) begin
            @(negedge clk_in);
            n++;
        end
        check("trig_width", n, 100);
        if (!rise) begin
            n = 0;
            while (!valid && n < 2000) begin
                @(negedge clk_in);
                n++;
            end
            check("echo_wait_lat", (n >= 1000 && n <= 1004) ? 1 : 0, 1);
        end else begin
            repeat (200) @(negedge clk_in);
            echo = 1'b1;
            if (stuck) begin
                n = 0;
                while (!valid && n < 25000) begin
                    @(negedge clk_in);
                    n++;
                end
                check("stuck_lat", (n >= 20000 && n <= 20010) ? 1 : 0, 1);
            end else begin
                for (int i = 0; i < int'(high_us * 10); i++) begin
                    @(negedge clk_in);
                    if (poke && i == 100) meas_req = 1'b0;
                    if (poke && i == 110) meas_req = 1'b1;
                end
                echo = 1'b0;
                repeat (3) @(posedge clk_in);
                #1 check("valid_early", valid, 0);
                @(posedge clk_in);
                #1 check("valid_lat", valid, 1);
                if (poke) begin
                    meas_req = 1'b0;
                    repeat (5) @(negedge clk_in);
                    meas_req = 1'b1;
                end
            end
        end
        n = 0;
        while (busy && n < 2000) begin
            @(negedge clk_in);
            n++;
        end
        check("busy_drop", busy, 0);
        check("dist_cm", dist_cm, exp_cm);
        check("timeout", timeout, exp_to);
        if (stuck) begin
            repeat (20) @(negedge clk_in);
            echo = 1'b0;
        end
        repeat (20) @(negedge clk_in);
        check("no_requeue", busy, 0);
        check("valid_count", valid_cnt - v0, 1);
    endtask

    initial begin
        int unsigned v0;
        repeat (3) @(negedge clk_in);
        check("rst_trig", trig, 0);
        check("rst_dist", dist_cm, 0);
        check("rst_valid", valid, 0);
        check("rst_timeout", timeout, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk_in);
        check("idle_busy", busy, 0);
        check("idle_trig", trig, 0);

        // Reset in the middle of the trigger pulse
        v0 = valid_cnt;
        meas_req = 1'b1;
        repeat (30) @(negedge clk_in);
        check("pre_rst_trig", trig, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_trig", trig, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", valid, 0);
        @(negedge clk_in);
        meas_req = 1'b0;
        rst = 1'b0;
        repeat (300) @(negedge clk_in);
        check("mid_rst_no_valid", valid_cnt - v0, 0);

        measure(580, 1, 0, 0, 10, 0);
        measure(579, 1, 0, 0, 9, 0);
        measure(58, 1, 0, 0, 1, 0);
        measure(0, 0, 0, 0, 400, 1);
        measure(1160, 1, 0, 0, 20, 0);
        measure(0, 1, 1, 0, 400, 1);
        measure(580, 1, 0, 1, 10, 0);
        measure(58, 1, 0, 0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
